// File: rtl/puzzle_move_ctrl_if.sv
// puzzle_move_ctrl_if -- command, status and board-memory signals of the
// 15-puzzle move controller.
//   init, cmd_valid, cmd_dir[1:0]   : requests into the controller
//   cmd_ready                       : controller can accept a move command
//   mem_addr/mem_wdata/mem_we       : single-port board memory, write side
//   mem_rdata                       : combinational read data for mem_addr
//   busy, done, illegal             : activity and completion pulses
//   blank_pos[3:0], move_cnt[15:0]  : blank cell index, legal move count
//   solved                          : board holds the solved pattern
// Modport slave is the controller; master is the environment driving it.
interface puzzle_move_ctrl_if;
    logic        init;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [3:0]  blank_pos;
    logic [15:0] move_cnt;
    logic        solved;

    modport master (
        output init, cmd_valid, cmd_dir, mem_rdata,
        input  cmd_ready, mem_addr, mem_wdata, mem_we,
               busy, done, illegal, blank_pos, move_cnt, solved
    );

    modport slave (
        input  init, cmd_valid, cmd_dir, mem_rdata,
        output cmd_ready, mem_addr, mem_wdata, mem_we,
               busy, done, illegal, blank_pos, move_cnt, solved
    );
endinterface

// File: rtl/puzzle_move_ctrl.sv
// puzzle_move_ctrl -- 4x4 sliding-puzzle controller. The board lives in an
// external single-port memory at BASE_ADDR+cell (mod 256); tile 0 is blank.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : puzzle_move_ctrl_if.slave (commands, status, board memory)
// Parameter BASE_ADDR: byte address of cell 0 (0..240).
// Optional build macro PUZZLE_SOLVED_CHECK_EN: after each legal move the
// whole board is re-read in a 16-cycle SCAN state and solved reflects the
// real board contents; without it solved is simply cleared by any move.
module puzzle_move_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    puzzle_move_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        WR_BLANK,
        WR_NBR
`ifdef PUZZLE_SOLVED_CHECK_EN
        , SCAN
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic        board_ok_q, board_ok_d;
    logic [3:0]  blank_q, blank_d;
    logic [15:0] cnt_q, cnt_d;
    logic        solved_q, solved_d;
    logic [3:0]  nbr_q, nbr_d;
    logic [7:0]  tile_q, tile_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
`ifdef PUZZLE_SOLVED_CHECK_EN
    logic        match_q, match_d;
`endif

    logic        cmd_ready_c;
    logic        legal_c;
    logic [3:0]  nbr_c;

    // Solved pattern: cell k holds k+1, last cell holds the blank.
    function automatic logic [7:0] pattern(input logic [3:0] idx);
        return (idx == 4'd15) ? 8'd0 : ({4'd0, idx} + 8'd1);
    endfunction

    function automatic logic [7:0] cell_addr(input logic [3:0] idx);
        return BASE_ADDR + {4'd0, idx};
    endfunction

    assign cmd_ready_c = (state_q == IDLE) && board_ok_q && !bus.init;

    // Neighbour of the blank in the requested direction and whether it is
    // still on the grid.
    always_comb begin
        legal_c = 1'b0;
        nbr_c   = blank_q;
        unique case (bus.cmd_dir)
            2'd0: begin legal_c = (blank_q[3:2] != 2'd0); nbr_c = blank_q - 4'd4; end
            2'd1: begin legal_c = (blank_q[3:2] != 2'd3); nbr_c = blank_q + 4'd4; end
            2'd2: begin legal_c = (blank_q[1:0] != 2'd0); nbr_c = blank_q - 4'd1; end
            2'd3: begin legal_c = (blank_q[1:0] != 2'd3); nbr_c = blank_q + 4'd1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        board_ok_d    = board_ok_q;
        blank_d       = blank_q;
        cnt_d         = cnt_q;
        solved_d      = solved_q;
        nbr_d         = nbr_q;
        tile_d        = tile_q;
        done_d        = 1'b0;
        illegal_d     = 1'b0;
`ifdef PUZZLE_SOLVED_CHECK_EN
        match_d       = match_q;
`endif
        bus.mem_addr  = BASE_ADDR;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.init) begin
                    state_d = INIT;
                    k_d     = '0;
                end else if (bus.cmd_valid && cmd_ready_c) begin
                    if (legal_c) begin
                        nbr_d   = nbr_c;
                        state_d = READ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            INIT: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = cell_addr(k_q);
                bus.mem_wdata = pattern(k_q);
                k_d           = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    blank_d    = 4'd15;
                    cnt_d      = '0;
                    solved_d   = 1'b1;
                    board_ok_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            READ: begin
                bus.mem_addr = cell_addr(nbr_q);
                tile_d       = bus.mem_rdata;
                state_d      = WR_BLANK;
            end
            WR_BLANK: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = cell_addr(blank_q);
                bus.mem_wdata = tile_q;
                state_d       = WR_NBR;
            end
            WR_NBR: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = cell_addr(nbr_q);
                bus.mem_wdata = '0;
                blank_d       = nbr_q;
                cnt_d         = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
`ifdef PUZZLE_SOLVED_CHECK_EN
                k_d           = '0;
                match_d       = 1'b1;
                state_d       = SCAN;
`else
                solved_d      = 1'b0;
                done_d        = 1'b1;
                state_d       = IDLE;
`endif
            end
`ifdef PUZZLE_SOLVED_CHECK_EN
            SCAN: begin
                bus.mem_addr = cell_addr(k_q);
                match_d      = match_q && (bus.mem_rdata == pattern(k_q));
                k_d          = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    solved_d = match_d;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            board_ok_q <= 1'b0;
            blank_q    <= 4'd15;
            cnt_q      <= '0;
            solved_q   <= 1'b0;
            nbr_q      <= '0;
            tile_q     <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef PUZZLE_SOLVED_CHECK_EN
            match_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            board_ok_q <= board_ok_d;
            blank_q    <= blank_d;
            cnt_q      <= cnt_d;
            solved_q   <= solved_d;
            nbr_q      <= nbr_d;
            tile_q     <= tile_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
`ifdef PUZZLE_SOLVED_CHECK_EN
            match_q    <= match_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
    assign bus.blank_pos = blank_q;
    assign bus.move_cnt  = cnt_q;
    assign bus.solved    = solved_q;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
module tb_puzzle_move_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wr_count;
    int   wc_save;
    logic [7:0] mem [256];

    puzzle_move_ctrl_if bus ();

    puzzle_move_ctrl #(.BASE_ADDR(8'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board memory: combinational read, write on the rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_init();
        bus.init      = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'd0;
        #1;
        chk("init_ready_low", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.init      = 1'b0;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("init_we",    32'(bus.mem_we),    32'd1);
            chk("init_addr",  32'(bus.mem_addr),  32'(k));
            chk("init_wdata", 32'(bus.mem_wdata), (k == 15) ? 32'd0 : 32'(k + 1));
            chk("init_busy",  32'(bus.busy),      32'd1);
            chk("init_done",  32'(bus.done),      32'd0);
            tick();
        end
        chk("init_blank",  32'(bus.blank_pos), 32'd15);
        chk("init_cnt",    32'(bus.move_cnt),  32'd0);
        chk("init_solved", 32'(bus.solved),    32'd1);
        chk("init_ready",  32'(bus.cmd_ready), 32'd1);
        chk("init_busy0",  32'(bus.busy),      32'd0);
        chk("init_nodone", 32'(bus.done),      32'd0);
    endtask

    task automatic do_move(input logic [1:0] dir, input logic [3:0] blk, input logic [3:0] nbr,
                           input logic [7:0] tile, input logic [15:0] cnt, input logic scan_solved);
        logic exp_solved;
`ifdef PUZZLE_SOLVED_CHECK_EN
        exp_solved = scan_solved;
`else
        exp_solved = 1'b0;
        if (scan_solved) exp_solved = 1'b0;
`endif
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        #1;
        chk("mv_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rd_we",      32'(bus.mem_we),    32'd0);
        chk("rd_addr",    32'(bus.mem_addr),  32'(nbr));
        chk("rd_data",    32'(bus.mem_rdata), 32'(tile));
        chk("rd_illegal", 32'(bus.illegal),   32'd0);
        chk("rd_busy",    32'(bus.busy),      32'd1);
        tick();
        chk("wb_we",    32'(bus.mem_we),    32'd1);
        chk("wb_addr",  32'(bus.mem_addr),  32'(blk));
        chk("wb_wdata", 32'(bus.mem_wdata), 32'(tile));
        tick();
        chk("wn_we",    32'(bus.mem_we),    32'd1);
        chk("wn_addr",  32'(bus.mem_addr),  32'(nbr));
        chk("wn_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("wn_done",  32'(bus.done),      32'd0);
        tick();
`ifdef PUZZLE_SOLVED_CHECK_EN
        for (int k = 0; k < 16; k++) begin
            chk("scan_we",    32'(bus.mem_we),    32'd0);
            chk("scan_addr",  32'(bus.mem_addr),  32'(k));
            chk("scan_ready", 32'(bus.cmd_ready), 32'd0);
            chk("scan_done",  32'(bus.done),      32'd0);
            tick();
        end
`endif
        chk("mv_done",   32'(bus.done),      32'd1);
        chk("mv_blank",  32'(bus.blank_pos), 32'(nbr));
        chk("mv_cnt",    32'(bus.move_cnt),  32'(cnt));
        chk("mv_solved", 32'(bus.solved),    32'(exp_solved));
        chk("mv_busy",   32'(bus.busy),      32'd0);
        tick();
        chk("mv_done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic do_illegal(input logic [1:0] dir, input logic [15:0] cnt);
        int wc;
        wc = wr_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        #1;
        chk("il_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("il_pulse", 32'(bus.illegal),  32'd1);
        chk("il_we",    32'(bus.mem_we),   32'd0);
        chk("il_busy",  32'(bus.busy),     32'd0);
        chk("il_done",  32'(bus.done),     32'd0);
        chk("il_cnt",   32'(bus.move_cnt), 32'(cnt));
        tick();
        chk("il_pulse_end", 32'(bus.illegal), 32'd0);
        chk("il_nowrite",   32'(wr_count),    32'(wc));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        wr_count      = 0;
        rst_n         = 1'b0;
        bus.init      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 2'd0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_busy",    32'(bus.busy),      32'd0);
        chk("rst_done",    32'(bus.done),      32'd0);
        chk("rst_illegal", 32'(bus.illegal),   32'd0);
        chk("rst_we",      32'(bus.mem_we),    32'd0);
        chk("rst_blank",   32'(bus.blank_pos), 32'd15);
        chk("rst_cnt",     32'(bus.move_cnt),  32'd0);
        chk("rst_solved",  32'(bus.solved),    32'd0);
        chk("rst_ready",   32'(bus.cmd_ready), 32'd0);
        chk("rst_addr",    32'(bus.mem_addr),  32'd0);
        chk("rst_wdata",   32'(bus.mem_wdata), 32'd0);

        // Commands before any init are never accepted
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("noinit_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("noinit_writes", 32'(wr_count), 32'd0);
        chk("noinit_busy",   32'(bus.busy), 32'd0);

        do_init();
        for (int k = 0; k < 16; k++)
            chk("init_mem", 32'(mem[k]), (k == 15) ? 32'd0 : 32'(k + 1));

        // Off-grid moves from the bottom-right corner
        do_illegal(2'd1, 16'd0);
        do_illegal(2'd3, 16'd0);

        // Up then down restores the board
        do_move(2'd0, 4'd15, 4'd11, 8'd12, 16'd1, 1'b0);
        chk("up_mem15", 32'(mem[15]), 32'd12);
        chk("up_mem11", 32'(mem[11]), 32'd0);
        do_move(2'd1, 4'd11, 4'd15, 8'd12, 16'd2, 1'b1);
        for (int k = 0; k < 16; k++)
            chk("restore_mem", 32'(mem[k]), (k == 15) ? 32'd0 : 32'(k + 1));

        // Walk the blank to column 0 then try to leave the grid
        do_move(2'd2, 4'd15, 4'd14, 8'd15, 16'd3, 1'b0);
        do_move(2'd2, 4'd14, 4'd13, 8'd14, 16'd4, 1'b0);
        do_move(2'd2, 4'd13, 4'd12, 8'd13, 16'd5, 1'b0);
        do_illegal(2'd2, 16'd5);

        // init wins over a simultaneous command and reloads the board
        do_init();
        for (int k = 0; k < 16; k++)
            chk("reinit_mem", 32'(mem[k]), (k == 15) ? 32'd0 : 32'(k + 1));

        // init ignored mid-move; reset during WR_BLANK aborts
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'd0;
        #1;
        chk("ab_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("ab_rd_addr", 32'(bus.mem_addr), 32'd11);
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        chk("ab_wb_we",    32'(bus.mem_we),    32'd1);
        chk("ab_wb_addr",  32'(bus.mem_addr),  32'd15);
        chk("ab_wb_wdata", 32'(bus.mem_wdata), 32'd12);
        rst_n = 1'b0;
        tick();
        wc_save = wr_count;
        chk("ab_busy",  32'(bus.busy),      32'd0);
        chk("ab_we",    32'(bus.mem_we),    32'd0);
        chk("ab_ready0", 32'(bus.cmd_ready), 32'd0);
        chk("ab_blank", 32'(bus.blank_pos), 32'd15);
        chk("ab_cnt",   32'(bus.move_cnt),  32'd0);
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ab_ready_low", 32'(bus.cmd_ready), 32'd0);
            chk("ab_we_low",    32'(bus.mem_we),    32'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("ab_nowrite", 32'(wr_count), 32'(wc_save));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puzzle_move_ctrl.md
PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'd0: byte address of board cell 0. Legal range is 0..240.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port init, input, 1 bit: request to load the solved board.
REQ-005 SHALL have port cmd_valid, input, 1 bit: move command valid.
REQ-006 SHALL have port cmd_dir, input, 2 bits: direction the blank moves (0 up, 1 down, 2 left, 3 right).
REQ-007 SHALL have port cmd_ready, output, 1 bit: controller can accept a command.
REQ-008 SHALL have ports mem_addr (output, 8 bits), mem_wdata (output, 8 bits), mem_we (output, 1 bit) and mem_rdata (input, 8 bits): the single-port memory interface; read data is combinational from mem_addr in the same cycle.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a legal move completes.
REQ-011 SHALL have port illegal, output, 1 bit: one-cycle pulse when a move is rejected.
REQ-012 SHALL have port blank_pos, output, 4 bits: cell index of the blank; row = [3:2], column = [1:0].
REQ-013 SHALL have port move_cnt, output, 16 bits: count of legal moves since the last init.
REQ-014 SHALL have port solved, output, 1 bit: board equals the solved pattern.

Function
REQ-015 SHALL map cell i to address BASE_ADDR+i, computed modulo 256. Tile value 0 is the blank.
REQ-016 SHALL implement states IDLE, INIT, READ, WR_BLANK, WR_NBR and, under the macro only, SCAN.
REQ-017 SHALL hold an internal board_ok flag, cleared by reset and set on INIT completion.
REQ-018 SHALL drive cmd_ready = (state==IDLE) && board_ok && !init.
- A command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-019 SHALL give init priority when init is asserted in IDLE:
- enter INIT, even if cmd_valid is high in the same cycle;
- the command is not accepted.
REQ-020 SHALL ignore init outside IDLE.
REQ-021 SHALL, in INIT, spend 16 cycles (k = 0..15) driving mem_we=1, mem_addr=BASE_ADDR+k and mem_wdata = k+1 (k<15) or 0 (k=15).
- After k=15: blank_pos=15, move_cnt=0, solved=1, board_ok=1, return to IDLE.
- done is not pulsed.
REQ-022 SHALL compute the neighbour index as blank_pos-4 (up), +4 (down), -1 (left) or +1 (right).
REQ-023 SHALL reject a move that leaves the grid: up at row 0, down at row 3, left at column 0, right at column 3.
- Pulse illegal in the cycle after acceptance (T+1).
- Perform no memory write; move_cnt unchanged; return to IDLE at T+1.
REQ-024 SHALL, for a legal move accepted at cycle T, sequence:
- T+1 READ: mem_addr = neighbour, mem_we=0; capture mem_rdata as tile.
- T+2 WR_BLANK: write tile to blank_pos.
- T+3 WR_NBR: write 0 to the neighbour.
- Then update blank_pos to the neighbour and increment move_cnt.
REQ-025 SHALL saturate move_cnt at 16'hFFFF.
REQ-026 SHALL drive mem_we=0 and mem_wdata=0 in all states except INIT, WR_BLANK and WR_NBR; mem_addr = BASE_ADDR in IDLE.
REQ-027 SHALL clear solved after every legal move when SOLVED_CHECK_EN is undefined.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set:
- state = IDLE, board_ok = 0;
- blank_pos = 15, move_cnt = 0, solved = 0;
- done = illegal = busy = mem_we = 0.
REQ-029 SHALL abort any in-progress INIT, move or SCAN on reset with no further writes. Board memory contents are not repaired.

Configuration
REQ-030 SHALL compile the solved-board scan in when macro PUZZLE_SOLVED_CHECK_EN is defined.
- After WR_NBR, enter SCAN for 16 cycles reading BASE_ADDR+0..15, comparing each cell against the REQ-021 pattern.
- solved = all match; done pulses at T+20, together with the solved update; cmd_ready stays low throughout.
REQ-031 SHALL, without PUZZLE_SOLVED_CHECK_EN, omit SCAN, pulse done at T+4 and drive solved per REQ-021/REQ-027.

Verification
REQ-032 Reset, then cmd_valid=1 with no init -> cmd_ready stays 0, no memory writes.
REQ-033 init pulse -> 16 writes: addr 0..15, data 1..15 then 0; blank_pos=15, solved=1, cmd_ready=1 after.
REQ-034 After init, cmd_dir=0 (up) -> read addr 11 (data 12); write 12 to addr 15, then 0 to addr 11; blank_pos=11, move_cnt=1, done at T+4 (T+20 with macro, solved=0).
REQ-035 After init, cmd_dir=1 (down) or 3 (right) -> illegal pulse at T+1, mem_we never 1, move_cnt=0.
REQ-036 Up then down -> board restored; with the macro solved=1 at second done, move_cnt=2.
REQ-037 rst_n low during WR_BLANK -> next cycle IDLE, mem_we=0, cmd_ready=0 until a new init.
